stopwatch_uart_report: RTL

Formats a stopwatch time sample into an ASCII line and pushes it byte-by-byte into the UART TX FIFO. It sits directly downstream of the stopwatch datapath's msec/sec/min/hour outputs and upstream of the TX FIFO write port. On a report request it snapshots the time fields so the line cannot tear, then emits `HH:MM:SS.CC` plus a line terminator under FIFO-full backpressure.

---
 rtl/stopwatch_pkg.sv | 28 ++
 rtl/stopwatch_uart_report_bin2ascii.sv | 19 +
 rtl/stopwatch_uart_report.sv | 124 ++++++++++++
 3 files changed

// File: rtl/stopwatch_pkg.sv
// Shared types and constants for the stopwatch UART report path.
// Build option: define REPORT_CRLF_EN to end each line with CR+LF (13 bytes);
// otherwise lines end with LF only (12 bytes).
package stopwatch_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [7:0] ASC_0     = 8'h30;
  localparam logic [7:0] ASC_COLON = 8'h3A;
  localparam logic [7:0] ASC_DOT   = 8'h2E;
  localparam logic [7:0] ASC_CR    = 8'h0D;
  localparam logic [7:0] ASC_LF    = 8'h0A;

  localparam int unsigned IDX_W    = 4;
  localparam int unsigned DIG_W    = 7;
  localparam logic [DIG_W-1:0] DIG_MAX = 7'd99;

`ifdef REPORT_CRLF_EN
  localparam int unsigned REPORT_LEN = 13;
`else
  localparam int unsigned REPORT_LEN = 12;
`endif

endpackage

// File: rtl/stopwatch_uart_report_bin2ascii.sv
// Two-digit binary-to-ASCII converter; values above 99 saturate to 99.
module bin2ascii_2dig
  import stopwatch_pkg::*;
(
  input  logic [DIG_W-1:0] bin,
  output logic [7:0]       tens_c,
  output logic [7:0]       units_c
);

  logic [DIG_W-1:0] sat;

  // Clamp, then split into decimal tens/units and offset into ASCII.
  always_comb begin
    sat     = (bin > DIG_MAX) ? DIG_MAX : bin;
    tens_c  = ASC_0 + 8'(sat / 7'd10);
    units_c = ASC_0 + 8'(sat % 7'd10);
  end

endmodule

// File: rtl/stopwatch_uart_report.sv
// Snapshots a stopwatch time and streams "HH:MM:SS.CC" plus a line
// terminator into the UART TX FIFO, honouring FIFO-full backpressure.
// Build option: REPORT_CRLF_EN selects a CR+LF terminator instead of LF.
module stopwatch_uart_report
  import stopwatch_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       i_report,
  input  logic [6:0] msec,
  input  logic [5:0] sec,
  input  logic [5:0] min,
  input  logic [4:0] hour,
  input  logic       tx_full,
  output logic       push,
  output logic [7:0] push_data,
  output logic       busy,
  output logic       done
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(REPORT_LEN - 1);

  state_t           state;
  logic [IDX_W-1:0] idx;
  logic [6:0]       snap_msec;
  logic [5:0]       snap_sec;
  logic [5:0]       snap_min;
  logic [4:0]       snap_hour;

  logic [7:0] hour_t, hour_u;
  logic [7:0] min_t,  min_u;
  logic [7:0] sec_t,  sec_u;
  logic [7:0] msec_t, msec_u;
  logic [7:0] line_byte;

  bin2ascii_2dig u_hour (.bin(7'(snap_hour)), .tens_c(hour_t), .units_c(hour_u));
  bin2ascii_2dig u_min  (.bin(7'(snap_min)),  .tens_c(min_t),  .units_c(min_u));
  bin2ascii_2dig u_sec  (.bin(7'(snap_sec)),  .tens_c(sec_t),  .units_c(sec_u));
  bin2ascii_2dig u_msec (.bin(snap_msec),     .tens_c(msec_t), .units_c(msec_u));

  // Report FSM: snapshot on request, advance index per accepted byte, pulse done.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      idx       <= '0;
      snap_msec <= '0;
      snap_sec  <= '0;
      snap_min  <= '0;
      snap_hour <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (i_report) begin
            snap_msec <= msec;
            snap_sec  <= sec;
            snap_min  <= min;
            snap_hour <= hour;
            idx       <= '0;
            busy      <= 1'b1;
            state     <= SEND;
          end
        end
        SEND: begin
          if (!tx_full) begin
            idx <= idx + IDX_W'(1);
            if (idx == LAST_IDX) begin
              done  <= 1'b1;
              state <= DONE;
            end
          end
        end
        DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

  // Select the line character for the current index.
  always_comb begin
    line_byte = 8'h00;
    case (idx)
      4'd0:  line_byte = hour_t;
      4'd1:  line_byte = hour_u;
      4'd2:  line_byte = ASC_COLON;
      4'd3:  line_byte = min_t;
      4'd4:  line_byte = min_u;
      4'd5:  line_byte = ASC_COLON;
      4'd6:  line_byte = sec_t;
      4'd7:  line_byte = sec_u;
      4'd8:  line_byte = ASC_DOT;
      4'd9:  line_byte = msec_t;
      4'd10: line_byte = msec_u;
`ifdef REPORT_CRLF_EN
      4'd11: line_byte = ASC_CR;
      4'd12: line_byte = ASC_LF;
`else
      4'd11: line_byte = ASC_LF;
`endif
      default: line_byte = 8'h00;
    endcase
  end

  // Write strobe follows FIFO space directly so resume has no bubble.
  always_comb begin
    push      = 1'b0;
    push_data = 8'h00;
    if (state == SEND) begin
      push      = !tx_full;
      push_data = line_byte;
    end
  end

endmodule
